// File: rtl/pixel_fetch_pkg.sv
// ----------------------------------------------------------------------------
// pixel_fetch_pkg
// Shared widths, state encoding and the transparency resolve helper for the
// SRAM pixel fetch path.
// ----------------------------------------------------------------------------
package pixel_fetch_pkg;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;
    localparam int WAIT_W = 3;

    // Sprite word value that lets the background show through
    localparam logic [DATA_W-1:0] TRANSPARENT_IDX_DEF = 16'h0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BG_RD = 2'd1,
        SP_RD = 2'd2,
        OUT   = 2'd3
    } fetch_state_t;

    // Opaque sprite pixels win; otherwise the background word is shown
    function automatic logic [DATA_W-1:0] resolve_pixel(
        input logic              hit,
        input logic [DATA_W-1:0] sp_word,
        input logic [DATA_W-1:0] bg_word,
        input logic [DATA_W-1:0] transparent
    );
        return (hit && (sp_word != transparent)) ? sp_word : bg_word;
    endfunction

endpackage

// File: rtl/sram_read_timer.sv
// ----------------------------------------------------------------------------
// sram_read_timer
// Wait-state counter shared by both SRAM read phases. Counts while i_run is
// high and flags o_done on the cycle the count reaches WAIT; the count then
// restarts from zero so the next read phase begins with a clean counter.
//   i_clk   : system clock
//   i_rst_n : synchronous active-low reset
//   i_run   : a read phase is in progress
//   o_done  : data may be sampled this cycle
// ----------------------------------------------------------------------------
module sram_read_timer
    import pixel_fetch_pkg::*;
#(
    parameter logic [WAIT_W-1:0] WAIT = 3'd1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_run,
    output logic o_done
);

    logic [WAIT_W-1:0] r_count;

    assign o_done = i_run && (r_count == WAIT);

    // Wait counter: held at zero outside read phases and after each sample
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= 3'd0;
        end else if (!i_run || o_done) begin
            r_count <= 3'd0;
        end else begin
            r_count <= r_count + 3'd1;
        end
    end

endmodule

// File: rtl/sram_pixel_fetcher.sv
// ----------------------------------------------------------------------------
// sram_pixel_fetcher
// Reads the background word (and the sprite word on a sprite hit) from SRAM
// for each requested pixel, resolves transparency and presents one colour
// index per pixel to the colour mapper.
//   Clk, Reset_n                 : clock, synchronous active-low reset
//   pixel_req, sprite_hit        : request strobe and sprite-hit flag
//   SPRITE_ADDR, background_ADDR : word addresses latched on accept
//   SRAM_ADDR, SRAM_CE_N/OE_N/WE_N, Data_from_SRAM : SRAM read interface
//   pixel_data, pixel_valid      : resolved colour index and its strobe
//   busy, overrun                : activity flag, sticky dropped-request flag
// All SRAM pins are registered from the next state so they are glitch free
// and line up exactly with the state they belong to.
// ----------------------------------------------------------------------------
module sram_pixel_fetcher
    import pixel_fetch_pkg::*;
#(
    parameter int unsigned       SRAM_WAIT       = 1,
    parameter logic [DATA_W-1:0] TRANSPARENT_IDX = TRANSPARENT_IDX_DEF
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              pixel_req,
    input  logic              sprite_hit,
    input  logic [ADDR_W-1:0] SPRITE_ADDR,
    input  logic [ADDR_W-1:0] background_ADDR,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N,
    input  logic [DATA_W-1:0] Data_from_SRAM,
    output logic [DATA_W-1:0] pixel_data,
    output logic              pixel_valid,
    output logic              busy,
    output logic              overrun
);

    localparam logic [WAIT_W-1:0] WAIT_CYC = SRAM_WAIT[WAIT_W-1:0];

    fetch_state_t      r_state;
    fetch_state_t      w_next_state;
    logic [ADDR_W-1:0] r_sp_addr;
    logic [ADDR_W-1:0] r_bg_addr;
    logic              r_hit;
    logic [DATA_W-1:0] r_bg_word;
    logic [DATA_W-1:0] r_sp_word;
    logic [ADDR_W-1:0] r_sram_addr;
    logic              r_sram_rd_n;
    logic [DATA_W-1:0] r_pixel_data;
    logic              r_pixel_valid;
    logic              r_busy;
    logic              r_overrun;

    logic              w_accept;
    logic              w_run;
    logic              w_done;
    logic              w_next_rd;
    logic [ADDR_W-1:0] w_next_addr;
    logic [DATA_W-1:0] w_bg_now;
    logic [DATA_W-1:0] w_sp_now;
    logic [DATA_W-1:0] w_pixel;

    assign w_accept = pixel_req && ((r_state == IDLE) || (r_state == OUT));
    assign w_run    = (r_state == BG_RD) || (r_state == SP_RD);

    sram_read_timer #(.WAIT(WAIT_CYC)) u_timer (
        .i_clk   (Clk),
        .i_rst_n (Reset_n),
        .i_run   (w_run),
        .o_done  (w_done)
    );

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    w_next_state = w_accept ? BG_RD : IDLE;
            BG_RD:   w_next_state = w_done ? (r_hit ? SP_RD : OUT) : BG_RD;
            SP_RD:   w_next_state = w_done ? OUT : SP_RD;
            OUT:     w_next_state = w_accept ? BG_RD : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // On accept the latch updates at the same edge, so the fresh input is used
    assign w_next_rd   = (w_next_state == BG_RD) || (w_next_state == SP_RD);
    assign w_next_addr = (w_next_state == BG_RD) ? (w_accept ? background_ADDR : r_bg_addr) :
                         (w_next_state == SP_RD) ? r_sp_addr : 20'h00000;

    // Words as they will be after this edge, so the pixel is resolved on entry to OUT
    assign w_bg_now = ((r_state == BG_RD) && w_done) ? Data_from_SRAM : r_bg_word;
    assign w_sp_now = ((r_state == SP_RD) && w_done) ? Data_from_SRAM : r_sp_word;
    assign w_pixel  = resolve_pixel(r_hit, w_sp_now, w_bg_now, TRANSPARENT_IDX);

    // State, request latches, captured words and registered outputs
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state       <= IDLE;
            r_sp_addr     <= 20'h00000;
            r_bg_addr     <= 20'h00000;
            r_hit         <= 1'b0;
            r_bg_word     <= 16'h0000;
            r_sp_word     <= 16'h0000;
            r_sram_addr   <= 20'h00000;
            r_sram_rd_n   <= 1'b1;
            r_pixel_data  <= 16'h0000;
            r_pixel_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_sp_addr <= SPRITE_ADDR;
                r_bg_addr <= background_ADDR;
                r_hit     <= sprite_hit;
            end
            if ((r_state == BG_RD) && w_done) begin
                r_bg_word <= Data_from_SRAM;
            end
            if ((r_state == SP_RD) && w_done) begin
                r_sp_word <= Data_from_SRAM;
            end
            // A request arriving mid-read is lost; remember that it happened
            if (pixel_req && w_run) begin
                r_overrun <= 1'b1;
            end
            if (w_next_state == OUT) begin
                r_pixel_data <= w_pixel;
            end
            r_sram_addr   <= w_next_addr;
            r_sram_rd_n   <= !w_next_rd;
            r_pixel_valid <= (w_next_state == OUT);
            r_busy        <= (w_next_state != IDLE);
        end
    end

    assign SRAM_ADDR   = r_sram_addr;
    assign SRAM_CE_N   = r_sram_rd_n;
    assign SRAM_OE_N   = r_sram_rd_n;
    assign SRAM_WE_N   = 1'b1;
    assign pixel_data  = r_pixel_data;
    assign pixel_valid = r_pixel_valid;
    assign busy        = r_busy;
    assign overrun     = r_overrun;

endmodule

// File: doc/sram_pixel_fetcher.md
Name: sram_pixel_fetcher

Overview:
- Responder side of the sprite/background address path.
- Accepts per-pixel SRAM_ADDR-style requests (a sprite address, a background address, and a sprite-hit flag).
- Performs the SRAM read cycles, resolves sprite transparency against the background word, and hands one 16-bit colour index per pixel to the colour mapper.
- Sits between the address computer and the SRAM pins; it is the only SRAM reader in the display path.

Parameters:
- SRAM_WAIT, 1: extra cycles the address is held before data is sampled (range 0–7).
- TRANSPARENT_IDX, 16'h0000: sprite word value meaning "show background".

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  synchronous, active-low reset
- pixel_req  in  1  one-cycle strobe: new pixel request
- sprite_hit  in  1  OR of all is_* object flags for this pixel
- SPRITE_ADDR  in  20  sprite-sheet word address
- background_ADDR  in  20  background word address
- SRAM_ADDR  out  20  address to SRAM
- SRAM_CE_N  out  1  chip enable, active low
- SRAM_OE_N  out  1  output enable, active low
- SRAM_WE_N  out  1  write enable, held 1 (read-only block)
- Data_from_SRAM  in  16  SRAM read data
- pixel_data  out  16  resolved colour index
- pixel_valid  out  1  one-cycle strobe: pixel_data updated
- busy  out  1  high whenever state != IDLE
- overrun  out  1  sticky: a request was dropped

Behaviour:
- Clk is the only clock. Reset_n is synchronous, active-low.
- Reset values: state IDLE; SRAM_ADDR 0; SRAM_CE_N, SRAM_OE_N, SRAM_WE_N all 1; pixel_data 0; pixel_valid 0; busy 0; overrun 0; internal latches 0.
- Reset mid-operation: abort the read in the next cycle. No pixel_valid is produced for the aborted request.
- States: IDLE, BG_RD, SP_RD, OUT.
- Accept condition: pixel_req=1 while state is IDLE or OUT. On accept, latch SPRITE_ADDR, background_ADDR and sprite_hit, then go to BG_RD with wait counter cleared.
- BG_RD:
  - SRAM_ADDR = latched background address; CE_N=0, OE_N=0.
  - Counter increments each cycle.
  - On the cycle counter==SRAM_WAIT, capture Data_from_SRAM into bg_word, clear the counter, and go to SP_RD if the latched hit=1, else go to OUT.
- SP_RD: same as BG_RD but uses the latched sprite address and captures into sp_word, then goes to OUT.
- OUT:
  - CE_N=1, OE_N=1, SRAM_ADDR=0.
  - pixel_valid=1 for exactly this cycle.
  - pixel_data = sp_word if hit=1 and sp_word != TRANSPARENT_IDX, else bg_word. pixel_data is registered and holds until the next OUT.
  - Next state: BG_RD if a request is accepted this cycle, else IDLE.
- Latency, measured from the accept cycle T:
  - No hit: pixel_valid at T+SRAM_WAIT+2.
  - Hit: pixel_valid at T+2·SRAM_WAIT+3.
  - With SRAM_WAIT=1: T+3 (no hit) and T+5 (hit).
- Dropped requests: pixel_req while in BG_RD or SP_RD is ignored (no latch update) and sets overrun=1. overrun is cleared only by reset.
- SRAM_WE_N is constant 1 in every state.
- Address width: 20 bits, passed through unmodified with no arithmetic.
- SRAM_WAIT=0: each read lasts one cycle, with data sampled in the same cycle the address is driven.
- Input changes after accept have no effect on the in-flight pixel.

Decomposition:
- Package pixel_fetch_pkg:
  - ADDR_W=20, DATA_W=16
  - typedef enum fetch_state_t {IDLE, BG_RD, SP_RD, OUT}
  - default TRANSPARENT_IDX constant
- Sub-module sram_read_timer (3-bit wait counter with clear and a done flag) is natural; instantiate it once and share it between BG_RD and SP_RD.

Test Plan:
- Reset behaviour: hold Reset_n=0 for 3 cycles with random inputs → all outputs equal their reset values; SRAM_CE_N/OE_N/WE_N=1; busy=0.
- Background-only read (SRAM_WAIT=1): pixel_req at T, sprite_hit=0, background_ADDR=20'h12345, model returns 16'h00AB → SRAM_ADDR=12345 during T+1..T+2; pixel_valid only at T+3; pixel_data=00AB.
- Opaque sprite: sprite_hit=1, SPRITE_ADDR=20'h00C05, sprite word 16'h0042, background word 16'h0007 → SRAM_ADDR=background address at T+1..T+2, sprite address at T+3..T+4; pixel_valid at T+5; pixel_data=0042.
- Transparent sprite: same as the opaque case but sprite word 16'h0000 → pixel_data=0007 at T+5.
- Back-to-back and overrun:
  - Second pixel_req at T+2 (during BG_RD) → dropped, overrun=1, first pixel completes normally.
  - pixel_req in the OUT cycle → accepted; BG_RD on the next cycle with no IDLE gap.
- Reset mid-read plus wait sweep:
  - Reset_n=0 at T+3 of a hit request → no pixel_valid; IDLE on the following cycle.
  - Repeat the background-only case with SRAM_WAIT=0 → pixel_valid at T+2.
  - Repeat the background-only case with SRAM_WAIT=3 → pixel_valid at T+5.
